icache_fetch_ctrl: RTL and testbench
====================================

# icache_fetch_ctrl

Direct-mapped instruction-cache controller between the multi-cycle MIPS fetch stage and the word-addressed instruction memory. It serves CPU fetch requests from an internal line store. On a miss it sequences a multi-word line refill from instruction memory, using a programmable wait per word. It also supports whole-cache flush, which is needed after the instruction image is reloaded.

## Interface
- LINE_WORDS, 4: words per line; power of two, ≥2
- NUM_LINES, 8: number of lines; power of two, ≥2
- MEM_LAT, 2: cycles `mem_addr` is held per word before `mem_instr` is sampled; ≥1

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  fetch request; held with `cpu_addr` stable until the `cpu_ready` cycle, inclusive
- cpu_addr  in  32  byte address; bits [1:0] ignored
- flush  in  1  invalidate all lines
- cpu_ready  out  1  single-cycle registered pulse; `cpu_instr` is valid in this cycle
- cpu_instr  out  32  fetched instruction; holds its last value between responses
- mem_addr  out  32  byte address to instruction memory (combinational read)
- mem_instr  in  32  instruction memory read data
- hit_count, miss_count  out  16 each  present only with `ICACHE_STATS_EN`

## Operation
- **Address split:**
  - OB = log2(LINE_WORDS), IB = log2(NUM_LINES).
  - Offset is `addr[OB+1:2]`.
  - Index is `addr[OB+IB+1:OB+2]`.
  - Tag is the remaining upper bits.
- **Storage:** per line, one valid bit, one tag, and LINE_WORDS data words.
- **FSM states:** IDLE, REFILL, RESP.
- **IDLE:**
  - If `flush` is high, clear all valid bits. `cpu_req` is not evaluated that cycle.
  - Else, if `cpu_req` is high and `cpu_ready` is low:
    - Hit (valid and tag match): register the word into `cpu_instr`, pulse `cpu_ready`, stay in IDLE.
    - Miss: latch tag and index, set word counter = 0 and wait counter = 0, go to REFILL.
  - `cpu_req` seen in the same cycle as `cpu_ready` is the tail of the previous request and is ignored.
- **REFILL:**
  - `mem_addr` = {latched tag, latched index, word counter, 2'b00}.
  - The wait counter counts 0..MEM_LAT-1.
  - When the wait counter reaches MEM_LAT-1, write `mem_instr` into line word [word counter], then increment the word counter.
  - After word LINE_WORDS-1 is written, set valid, write the tag, and go to RESP.
  - The line is fetched starting from word 0, not critical-word-first.
- **RESP:** drive `cpu_instr` = refilled word [request offset], pulse `cpu_ready`, go to IDLE.
- **mem_addr:** 32'h0 in every state other than REFILL.
- **Flush during REFILL or RESP:** latched as pending and applied on the first IDLE cycle. The just-refilled line is invalidated too. `cpu_req` is not evaluated in that cycle.
- **Reset:**
  - State goes to IDLE, all valid bits clear, counters clear, pending flush clears.
  - `cpu_ready` = 0, `cpu_instr` = 0, `mem_addr` = 0.
  - Reset mid-refill aborts the refill. The line stays invalid because valid is set only on completion.

## Timing
- **Hit:** request sampled in IDLE at cycle T → `cpu_ready` at T+1.
- **Miss:** request sampled at T.
  - REFILL occupies T+1 .. T+LINE_WORDS·MEM_LAT.
  - `cpu_ready` at T+1+LINE_WORDS·MEM_LAT. With defaults, that is T+9.
- **mem_addr for word k:** valid from T+1+k·MEM_LAT for MEM_LAT cycles. Sampled on the last of those cycles.
- **Back-to-back hits:** one response every 2 cycles (request, ready, request, ready, …).
- **Flush in IDLE:** takes effect for a request sampled at T+1.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` and `miss_count` ports exist.
  - Each is incremented in the cycle a hit or miss is detected in IDLE.
  - Both saturate at 16'hFFFF.
  - Both clear on `reset` only; `flush` does not clear them.
- `ICACHE_STATS_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
Memory is loaded with the standard fetch image: word 0 = 32'h8C090028, word 2 = 32'h08000000, word 32 = 32'h00000000.

1. Reset, then `cpu_req` with addr 0x0 at T → `mem_addr` 0x0, 0x4, 0x8, 0xC, each held 2 cycles; `cpu_ready`=1 only at T+9; `cpu_instr`=32'h8C090028.
2. Then `cpu_req` with addr 0x8 at T → `cpu_ready` at T+1; `cpu_instr`=32'h08000000; `mem_addr` stays 0.
3. Conflict: request addr 0x80 (index 0, tag 1) → miss, `cpu_instr`=0 at T+9; then request addr 0x0 → miss again with 9-cycle latency.
4. Pulse `flush` in IDLE, then request addr 0x8 → miss with 9-cycle latency. Pulse `flush` during REFILL → that request still completes, but an immediate repeat request misses.
5. Assert `reset` in the 3rd REFILL cycle → next cycle `cpu_ready`=0, `mem_addr`=0, `cpu_instr`=0; a following request to addr 0x0 misses with full latency.
6. With `ICACHE_STATS_EN`: scenarios 1–2 leave `hit_count`=1 and `miss_count`=1. Forcing `hit_count` near saturation and issuing repeat hits leaves it stuck at 16'hFFFF.

Source files
------------

// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped I-cache fetch controller with multi-word line refill.
// Optional hit/miss counters: define ICACHE_STATS_EN.
module icache_fetch_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8,
  parameter int MEM_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic        flush,
  output logic        cpu_ready,
  output logic [31:0] cpu_instr,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TW = 30 - OB - IB;
  localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]           state;
  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0]        tags [NUM_LINES];
  logic [31:0]          data [NUM_LINES][LINE_WORDS];

  logic [TW-1:0] r_tag;
  logic [IB-1:0] r_idx;
  logic [OB-1:0] r_off;
  logic [OB-1:0] wcnt;
  logic [WW-1:0] lcnt;
  logic          fpend;

  logic [OB-1:0] a_off;
  logic [IB-1:0] a_idx;
  logic [TW-1:0] a_tag;
  logic          look;
  logic          hit;
  logic          word_done;
  logic          last_word;
  logic          unused_addr;

  assign a_off       = cpu_addr[OB+1:2];
  assign a_idx       = cpu_addr[OB+IB+1:OB+2];
  assign a_tag       = cpu_addr[31:OB+IB+2];
  assign unused_addr = ^cpu_addr[1:0];

  // A request alongside cpu_ready is the tail of the one just answered.
  assign look = (state == IDLE) && !flush && !fpend
              && cpu_req && !cpu_ready;
  assign hit  = valid[a_idx] && (tags[a_idx] == a_tag);

  assign word_done = (state == REFILL)
                   && (lcnt == WW'(MEM_LAT - 1));
  assign last_word = (wcnt == OB'(LINE_WORDS - 1));

  assign mem_addr = (state == REFILL)
                  ? {r_tag, r_idx, wcnt, 2'b00}
                  : 32'h0;

  always_ff @(posedge clk) begin
    if (word_done) begin
      data[r_idx][wcnt] <= mem_instr;
      if (last_word) tags[r_idx] <= r_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= '0;
      r_tag     <= '0;
      r_idx     <= '0;
      r_off     <= '0;
      wcnt      <= '0;
      lcnt      <= '0;
      fpend     <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_instr <= 32'h0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (flush || fpend) begin
            valid <= '0;
            fpend <= 1'b0;
          end else if (look) begin
            if (hit) begin
              cpu_ready <= 1'b1;
              cpu_instr <= data[a_idx][a_off];
            end else begin
              r_tag <= a_tag;
              r_idx <= a_idx;
              r_off <= a_off;
              wcnt  <= '0;
              lcnt  <= '0;
              state <= REFILL;
            end
          end
        end
        REFILL: begin
          if (flush) fpend <= 1'b1;
          if (word_done) begin
            lcnt <= '0;
            wcnt <= wcnt + 1'b1;
            if (last_word) begin
              valid[r_idx] <= 1'b1;
              state        <= RESP;
              cpu_ready    <= 1'b1;
              // The requested word may be the one arriving right now.
              cpu_instr    <= (r_off == wcnt) ? mem_instr
                            : data[r_idx][r_off];
            end
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        RESP: begin
          if (flush) fpend <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= 16'h0;
      miss_count <= 16'h0;
    end else if (look) begin
      if (hit && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'h1;
      if (!hit && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Randomized bench for icache_fetch_ctrl against a line-level
// cache model (valid/tag per line, latency from hit/miss rules).
module tb_icache_fetch_ctrl;

  localparam int LW  = 4;
  localparam int NL  = 8;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        flush;
  logic        cpu_ready;
  logic [31:0] cpu_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  assign mem_instr = mem[mem_addr[11:2]];

  icache_fetch_ctrl #(
    .LINE_WORDS(LW),
    .NUM_LINES (NL),
    .MEM_LAT   (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .flush     (flush),
    .cpu_ready (cpu_ready),
    .cpu_instr (cpu_instr),
    .mem_addr  (mem_addr),
    .mem_instr (mem_instr)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  bit          vld_m [NL];
  logic [31:0] tag_m [NL];
  bit          pend_m;
  int          hits_m;
  int          miss_m;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic inval_all();
    for (int i = 0; i < NL; i++) vld_m[i] = 1'b0;
  endtask

  task automatic idle(input int k);
    cpu_req = 1'b0;
    flush   = 1'b0;
    repeat (k) @(negedge clk);
    if (k > 0 && pend_m) begin
      inval_all();
      pend_m = 1'b0;
    end
  endtask

  task automatic do_flush();
    cpu_req = 1'b0;
    flush   = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    inval_all();
    pend_m = 1'b0;
  endtask

  // fl_at / rst_at: refill cycle (1-based) to pulse flush / reset in.
  task automatic do_req(input logic [31:0] addr,
                        input int fl_at,
                        input int rst_at);
    int          idx;
    logic [31:0] tag;
    logic [31:0] base;
    logic [31:0] ea;
    int          extra;
    int          lat;
    int          n;
    int          m;
    bit          h;
    chk("idle_rdy", {31'b0, cpu_ready}, 32'h0);
    extra = pend_m ? 1 : 0;
    if (pend_m) begin
      inval_all();
      pend_m = 1'b0;
    end
    idx  = int'(addr[6:4]);
    tag  = addr >> 7;
    base = {addr[31:4], 4'b0};
    h    = vld_m[idx] && (tag_m[idx] == tag);
    lat  = extra + (h ? 1 : 1 + LW * LAT);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    n = 0;
    do begin
      flush = !h && fl_at > 0 && n == extra + fl_at;
      if (!h && rst_at > 0 && n == extra + rst_at) begin
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_rdy", {31'b0, cpu_ready}, 32'h0);
        chk("rst_madr", mem_addr, 32'h0);
        chk("rst_instr", cpu_instr, 32'h0);
        inval_all();
        pend_m = 1'b0;
        hits_m = 0;
        miss_m = 0;
        return;
      end
      @(negedge clk);
      n++;
      flush = 1'b0;
      m  = n - extra;
      ea = 32'h0;
      if (!h && m >= 1 && m <= LW * LAT)
        ea = base + 32'((m - 1) / LAT * 4);
      chk("madr", mem_addr, ea);
    end while (!cpu_ready && n < 64);
    chk("lat", n, lat);
    chk("instr", cpu_instr, mem[addr[11:2]]);
    if (h) begin
      if (hits_m < 65535) hits_m++;
    end else begin
      if (miss_m < 65535) miss_m++;
      vld_m[idx] = 1'b1;
      tag_m[idx] = tag;
      if (fl_at > 0) pend_m = 1'b1;
    end
    // cpu_req stays high through this edge: the ignored tail.
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    if ($urandom_range(0, 3) == 0)
      a = 32'($urandom_range(0, 1023)) << 2;
    else
      a = 32'($urandom_range(0, 255)) << 2;
    return a | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0]  = 32'h8C090028;
    mem[2]  = 32'h08000000;
    mem[32] = 32'h00000000;
    inval_all();
    pend_m   = 1'b0;
    hits_m   = 0;
    miss_m   = 0;
    reset    = 1'b1;
    cpu_req  = 1'b0;
    flush    = 1'b0;
    cpu_addr = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("init_rdy", {31'b0, cpu_ready}, 32'h0);
    chk("init_instr", cpu_instr, 32'h0);
    chk("init_madr", mem_addr, 32'h0);

    do_req(32'h0, 0, 0);
    chk("t1_instr", cpu_instr, 32'h8C090028);
    do_req(32'h8, 0, 0);
    chk("t2_instr", cpu_instr, 32'h08000000);
`ifdef ICACHE_STATS_EN
    chk("t6_hits", {16'h0, hit_count}, 32'd1);
    chk("t6_miss", {16'h0, miss_count}, 32'd1);
`endif
    do_req(32'h80, 0, 0);
    chk("t3_instr", cpu_instr, 32'h0);
    do_req(32'h0, 0, 0);
    do_flush();
    do_req(32'h8, 0, 0);
    do_req(32'h14, 3, 0);
    do_req(32'h14, 0, 0);
    do_req(32'h0, 0, 3);
    do_req(32'h0, 0, 0);
    do_req(32'h4, 0, 0);

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 99);
      if (r < 5)       do_flush();
      else if (r < 12) idle($urandom_range(1, 3));
      else if (r < 15) do_req(rnd_addr(), 0, $urandom_range(1, LW * LAT));
      else if (r < 25) do_req(rnd_addr(), $urandom_range(1, LW * LAT), 0);
      else             do_req(rnd_addr(), 0, 0);
    end
    idle(1);

`ifdef ICACHE_STATS_EN
    chk("hits", {16'h0, hit_count}, 32'(hits_m));
    chk("miss", {16'h0, miss_count}, 32'(miss_m));
    do_req(32'h0, 0, 0);
    force dut.hit_count = 16'hFFFD;
    @(negedge clk);
    release dut.hit_count;
    hits_m = 65533;
    repeat (4) do_req(32'h0, 0, 0);
    chk("hit_sat", {16'h0, hit_count}, 32'h0000FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
